rip_fetch: RTL and testbench

Instruction fetch stage of the rip-cpu pipeline. Owns the program counter, issues word requests to instruction memory over a request/grant/response handshake and buffers returned words in a small FIFO. Presents one instruction per cycle to the decode stage on `inst_code`/`de_ready`, honours execute-stage stalls and flushes on PC redirects (jumps, taken branches, ECALL/EBREAK).

---
 rtl/rip_fetch.sv | 137 +++++++++++++
 tb/tb_rip_fetch.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rip_fetch.sv
// rip_fetch: instruction fetch stage - owns the PC, keeps one imem request in flight, buffers words in a FIFO.
// Optional feature macro RIP_FETCH_MISALIGN_FAULT_EN: misaligned redirect targets raise fetch_fault and halt fetch.
module rip_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        de_ready,
    output logic [31:0] inst_code,
    output logic [31:0] inst_pc,
    output logic        fetch_fault
);
    localparam int            AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int            CW      = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [31:0]   NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t         state, state_nxt;
    logic [31:0]    pc, pc_of_req, tgt_pc;
    logic [31:0]    fifo_code [FIFO_DEPTH];
    logic [31:0]    fifo_pc   [FIFO_DEPTH];
    logic [AW-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]  count, count_nxt;
    logic           push, pop, grant, empty;
    logic           fault, fault_nxt, tgt_bad;

    assign tgt_pc = redirect_pc & 32'hFFFF_FFFC;

`ifdef RIP_FETCH_MISALIGN_FAULT_EN
    assign tgt_bad = |redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (!rst_n)
            fault <= 1'b0;
        else if (redirect)
            fault <= tgt_bad;
    end
`else
    assign tgt_bad = 1'b0;
    assign fault   = 1'b0;
`endif

    assign fault_nxt   = redirect ? tgt_bad : fault;
    assign fetch_fault = fault;

    // Decode side is purely combinational from FIFO state; redirect blocks the pop it would flush anyway.
    assign empty     = (count == '0);
    assign pop       = !empty && !ex_stall && !redirect;
    assign de_ready  = pop;
    assign inst_code = empty ? NOP   : fifo_code[rd_ptr];
    assign inst_pc   = empty ? 32'h0 : fifo_pc[rd_ptr];

    // A redirect withdraws the request combinationally so memory never grants a flushed address.
    assign imem_req  = (state == REQ) && !redirect;
    assign imem_addr = pc;

    assign push      = (state == WAIT) && imem_rvalid && !redirect;
    assign count_nxt = count + CW'(push) - CW'(pop);

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        case (state)
            IDLE: begin
                if (!fault_nxt && (redirect || count < DEPTH_C))
                    state_nxt = REQ;
            end
            REQ: begin
                if (redirect)
                    state_nxt = IDLE;
                else if (imem_gnt) begin
                    grant     = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (redirect)
                    state_nxt = imem_rvalid ? IDLE : DROP;
                else if (imem_rvalid)
                    state_nxt = (count_nxt < DEPTH_C) ? REQ : IDLE;
            end
            DROP: begin
                if (imem_rvalid)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_nxt;
            if (redirect)
                pc <= tgt_pc;
            else if (grant)
                pc <= pc + 32'd4;
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                count <= count_nxt;
            end
        end
    end

    // Datapath storage: only ever read when qualified by state or a non-empty count.
    always_ff @(posedge clk) begin
        if (grant)
            pc_of_req <= pc;
        if (push) begin
            fifo_code[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]   <= pc_of_req;
        end
    end
endmodule

// File: tb/tb_rip_fetch.sv
// Bench for rip_fetch: random-latency imem model, expected instruction stream queue, negedge monitor.
module tb_rip_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef RIP_FETCH_MISALIGN_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        de_ready;
    logic [31:0] inst_code;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    rip_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .ex_stall(ex_stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .de_ready(de_ready), .inst_code(inst_code), .inst_pc(inst_pc),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] code;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] next_pc = RESET_PC;
    logic [31:0] gexp = RESET_PC;
    bit          fault_exp = 1'b0;
    bit          no_grant = 1'b0;
    int          total = 0;
    int          bad = 0;
    int          pops = 0;
    int          gnt_pct = 100;
    int          lat_min = 0;
    int          lat_max = 0;
    bit          pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          lat_cnt = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0)
            return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic top_up();
        exp_t e;
        while (exp_q.size() < 32) begin
            e.pc   = next_pc;
            e.code = mem_word(next_pc);
            exp_q.push_back(e);
            next_pc = next_pc + 32'd4;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (!fault_exp)
            top_up();
    endtask

    // Holds reset two edges, checks reset values, releases right after an edge that sampled reset.
    task automatic do_reset();
        rst_n = 1'b0;
        redirect = 1'b0;
        ex_stall = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_imem_addr", imem_addr, RESET_PC);
        chk("rst_de_ready", 32'(de_ready), 32'd0);
        chk("rst_inst_code", inst_code, 32'h0000_0013);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_fetch_fault", 32'(fetch_fault), 32'd0);
        @(posedge clk);
        #1;
        exp_q.delete();
        next_pc = RESET_PC;
        gexp = RESET_PC;
        fault_exp = 1'b0;
        no_grant = 1'b0;
        top_up();
        rst_n = 1'b1;
    endtask

    task automatic do_redirect(input logic [31:0] tgt);
        bit misal;
        @(posedge clk);
        #1;
        redirect = 1'b1;
        redirect_pc = tgt;
        exp_q.delete();
        misal = FAULT_EN && (tgt[1:0] != 2'b00);
        fault_exp = misal;
        no_grant = misal;
        if (!misal) begin
            next_pc = tgt & 32'hFFFF_FFFC;
            gexp = next_pc;
            top_up();
        end
        @(posedge clk);
        #1;
        redirect = 1'b0;
        @(negedge clk);
        chk("fetch_fault_after_redirect", 32'(fetch_fault), 32'(misal));
    endtask

    // Memory driver: grants at random, answers the single outstanding request after its latency.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (pend && lat_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata = mem_word(pend_addr);
            end
            imem_gnt = ($urandom_range(1, 100) <= gnt_pct);
        end
    end

    // Memory observer: expected address sequence and single-outstanding rule.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (imem_rvalid)
                    pend = 1'b0;
                else if (pend && lat_cnt != 0)
                    lat_cnt--;
                if (no_grant)
                    chk("no_req_while_fault", 32'(imem_req), 32'd0);
                if (imem_req && imem_gnt) begin
                    chk("one_outstanding", 32'(pend), 32'd0);
                    chk("grant_addr", imem_addr, gexp);
                    gexp = imem_addr + 32'd4;
                    pend = 1'b1;
                    pend_addr = imem_addr;
                    lat_cnt = $urandom_range(lat_min, lat_max);
                end
            end
        end
    end

    // Decode-side monitor: every consumed instruction must be the next one of the expected stream.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (redirect)
                    chk("no_pop_on_redirect", 32'(de_ready), 32'd0);
                if (de_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_pop: got pc %h expected no instruction", inst_pc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("inst_pc", inst_pc, e.pc);
                        chk("inst_code", inst_code, e.code);
                        pops++;
                    end
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        int          p0;
        bit          found;
        logic [31:0] tgt;
        int          r;

        // First fetch with a single-cycle memory.
        gnt_pct = 100; lat_min = 0; lat_max = 0;
        do_reset();
        @(negedge clk);
        chk("c0_no_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        chk("c1_req", 32'(imem_req), 32'd1);
        chk("c1_addr", imem_addr, RESET_PC);
        @(negedge clk);
        @(negedge clk);
        chk("c3_de_ready", 32'(de_ready), 32'd1);
        chk("c3_inst_code", inst_code, 32'h0050_0093);
        chk("c3_inst_pc", inst_pc, 32'h0);
        repeat (6) tick();

        // Stall fills the buffer, then drains in order.
        do_reset();
        ex_stall = 1'b1;
        repeat (8) @(negedge clk);
        chk("full_req_low", 32'(imem_req), 32'd0);
        chk("full_no_ready", 32'(de_ready), 32'd0);
        chk("full_head_pc", inst_pc, 32'h0);
        chk("full_head_code", inst_code, 32'h0050_0093);
        @(posedge clk);
        #1;
        ex_stall = 1'b0;
        p0 = pops;
        repeat (6) @(negedge clk);
        chk("drain_pops", 32'((pops - p0) >= 2), 32'd1);
        repeat (4) tick();

        // Redirect while the request for 0x8 is outstanding with a slow memory.
        lat_min = 2; lat_max = 2;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (imem_req && imem_gnt && imem_addr == 32'h8)
                found = 1'b1;
        end
        chk("grant_0x8_seen", 32'(found), 32'd1);
        do_redirect(32'h0000_0100);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (de_ready) begin
                found = 1'b1;
                chk("first_pc_after_redirect", inst_pc, 32'h100);
            end
        end
        chk("pop_after_redirect_seen", 32'(found), 32'd1);

        // Wrap of the PC and misaligned target handling.
        lat_min = 0; lat_max = 0;
        do_redirect(32'hFFFF_FFF8);
        repeat (20) tick();
        do_redirect(32'h0000_0102);
        repeat (10) tick();
        do_redirect(32'h0000_0200);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (de_ready) begin
                found = 1'b1;
                chk("resume_pc", inst_pc, 32'h200);
            end
        end
        chk("resume_seen", 32'(found), 32'd1);

        // Random traffic: stalls, redirects, latencies, occasional reset.
        for (int i = 0; i < 1500; i++) begin
            if (i % 200 == 0) begin
                gnt_pct = $urandom_range(30, 100);
                lat_min = 0;
                lat_max = $urandom_range(0, 4);
            end
            r = $urandom_range(0, 399);
            if (r < 16) begin
                tgt = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
                if ($urandom_range(0, 3) == 0)
                    tgt[1:0] = 2'($urandom_range(1, 3));
                if ($urandom_range(0, 7) == 0)
                    tgt[31:12] = 20'hFFFFF;
                do_redirect(tgt);
            end else if (r == 16) begin
                do_reset();
            end else begin
                tick();
                ex_stall = ($urandom_range(0, 3) == 0);
            end
        end
        ex_stall = 1'b0;
        repeat (10) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
